// File: rtl/pour_sequencer_pkg.sv
// Shared definitions for the cocktail dispenser: state encodings (also used by
// the display driver), selection limits and the per-drink recipe table.
package pour_sequencer_pkg;

    localparam logic [1:0] ST_ORDER     = 2'b00;
    localparam logic [1:0] ST_CUSTOMIZE = 2'b01;
    localparam logic [1:0] ST_START     = 2'b10;
    localparam logic [1:0] ST_DONE      = 2'b11;

    localparam logic [2:0] MAX_DRINK = 3'd6;
    localparam logic [3:0] MIN_SIZE  = 4'd1;
    localparam logic [3:0] MAX_SIZE  = 4'd9;
    localparam int         MAX_STEPS = 4;

    typedef struct packed {
        logic [1:0] pump_id;
        logic [2:0] parts;
    } recipe_step_t;

    // A step with zero parts terminates the recipe; row 7 is an unused drink code.
    localparam recipe_step_t RECIPE_TABLE [8][MAX_STEPS] = '{
        '{'{2'd0, 3'd2}, '{2'd1, 3'd1}, '{2'd0, 3'd0}, '{2'd0, 3'd0}},
        '{'{2'd0, 3'd1}, '{2'd2, 3'd2}, '{2'd0, 3'd0}, '{2'd0, 3'd0}},
        '{'{2'd1, 3'd3}, '{2'd0, 3'd0}, '{2'd0, 3'd0}, '{2'd0, 3'd0}},
        '{'{2'd2, 3'd1}, '{2'd3, 3'd1}, '{2'd0, 3'd0}, '{2'd0, 3'd0}},
        '{'{2'd0, 3'd1}, '{2'd1, 3'd1}, '{2'd2, 3'd1}, '{2'd0, 3'd0}},
        '{'{2'd3, 3'd2}, '{2'd0, 3'd1}, '{2'd0, 3'd0}, '{2'd0, 3'd0}},
        '{'{2'd1, 3'd1}, '{2'd2, 3'd1}, '{2'd3, 3'd1}, '{2'd0, 3'd1}},
        '{'{2'd0, 3'd0}, '{2'd0, 3'd0}, '{2'd0, 3'd0}, '{2'd0, 3'd0}}
    };

    function automatic logic [5:0] pour_units(input logic [2:0] parts, input logic [3:0] size);
        logic [6:0] product;
        product = 7'(parts) * 7'(size);
        return product[5:0];
    endfunction

    function automatic logic [3:0] pump_onehot(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

endpackage

// File: rtl/pour_sequencer_recipe_rom.sv
// Combinational recipe lookup: pump and parts for one step of one drink, with
// valid cleared once the step lies at or beyond the recipe's terminator.
module recipe_rom
    import pour_sequencer_pkg::*;
(
    input  logic [2:0] drink,
    input  logic [1:0] step,
    output logic [1:0] pump_id,
    output logic [2:0] parts,
    output logic       valid
);

    recipe_step_t entry;

    always_comb begin
        entry   = RECIPE_TABLE[drink][step];
        pump_id = entry.pump_id;
        parts   = entry.parts;
        valid   = 1'b1;
        for (int i = 0; i < MAX_STEPS; i++) begin
            if (i <= int'(step) && RECIPE_TABLE[drink][2'(i)].parts == 3'd0) begin
                valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pour_sequencer.sv
// Dispenser top-level controller: order/customize/start flow, drink and size
// selection, and timed sequencing of the pump enables through a recipe.
module pour_sequencer
    import pour_sequencer_pkg::*;
#(
    parameter int UNIT_CYCLES = 100000000,
    parameter int DONE_CYCLES = 200000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_ok,
    input  logic       btn_back,
    output logic [1:0] state,
    output logic [2:0] drink,
    output logic [3:0] size,
    output logic [3:0] pump,
    output logic       done
);

    localparam int UNIT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int DONE_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

    logic [1:0]        state_q, state_d;
    logic [2:0]        drink_q, drink_d;
    logic [3:0]        size_q, size_d;
    logic [3:0]        pump_q, pump_d;
    logic              done_q, done_d;
    logic [1:0]        step_q, step_d;
    logic [UNIT_W-1:0] unit_cnt_q, unit_cnt_d;
    logic [5:0]        units_left_q, units_left_d;
    logic [DONE_W-1:0] done_cnt_q, done_cnt_d;

    logic [1:0] rom_step;
    logic [1:0] rom_pump_id;
    logic [2:0] rom_parts;
    logic       rom_valid;
    logic       unit_wrap;
    logic       next_step_valid;

    // Outside START the ROM shows step 0 so the first pump can load on entry;
    // during a pour it looks one step ahead for a gapless hand-over.
    always_comb begin
        rom_step        = (state_q == ST_START) ? step_q + 2'd1 : 2'd0;
        unit_wrap       = (unit_cnt_q == UNIT_W'(UNIT_CYCLES - 1));
        next_step_valid = rom_valid && (step_q != 2'd3);
    end

    recipe_rom u_recipe_rom (
        .drink   (drink_q),
        .step    (rom_step),
        .pump_id (rom_pump_id),
        .parts   (rom_parts),
        .valid   (rom_valid)
    );

    always_comb begin
        state_d      = state_q;
        drink_d      = drink_q;
        size_d       = size_q;
        pump_d       = pump_q;
        done_d       = done_q;
        step_d       = step_q;
        unit_cnt_d   = unit_cnt_q;
        units_left_d = units_left_q;
        done_cnt_d   = done_cnt_q;

        case (state_q)
            ST_ORDER: begin
                if (btn_back) begin
                    state_d = ST_ORDER;
                end else if (btn_ok) begin
                    state_d = ST_CUSTOMIZE;
                end else if (btn_next) begin
                    drink_d = (drink_q == MAX_DRINK) ? 3'd0 : drink_q + 3'd1;
                end
            end
            ST_CUSTOMIZE: begin
                if (btn_back) begin
                    state_d = ST_ORDER;
                end else if (btn_ok) begin
                    state_d      = ST_START;
                    step_d       = 2'd0;
                    unit_cnt_d   = '0;
                    units_left_d = pour_units(rom_parts, size_q);
                    pump_d       = pump_onehot(rom_pump_id);
                end else if (btn_next) begin
                    size_d = (size_q == MAX_SIZE) ? MIN_SIZE : size_q + 4'd1;
                end
            end
            ST_START: begin
                if (btn_back) begin
                    state_d = ST_ORDER;
                    pump_d  = 4'b0000;
                end else if (unit_wrap) begin
                    unit_cnt_d = '0;
                    if (units_left_q == 6'd1) begin
                        if (next_step_valid) begin
                            step_d       = step_q + 2'd1;
                            units_left_d = pour_units(rom_parts, size_q);
                            pump_d       = pump_onehot(rom_pump_id);
                        end else begin
                            state_d    = ST_DONE;
                            pump_d     = 4'b0000;
                            done_d     = 1'b1;
                            done_cnt_d = '0;
                        end
                    end else begin
                        units_left_d = units_left_q - 6'd1;
                    end
                end else begin
                    unit_cnt_d = unit_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                pump_d = 4'b0000;
                if (done_cnt_q == DONE_W'(DONE_CYCLES - 1)) begin
                    state_d    = ST_ORDER;
                    done_d     = 1'b0;
                    size_d     = MIN_SIZE;
                    done_cnt_d = '0;
                end else begin
                    done_cnt_d = done_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_ORDER;
                pump_d  = 4'b0000;
                done_d  = 1'b0;
            end
        endcase
    end

    // Asynchronous reset drops every pump enable without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ORDER;
            drink_q      <= 3'd0;
            size_q       <= MIN_SIZE;
            pump_q       <= 4'b0000;
            done_q       <= 1'b0;
            step_q       <= 2'd0;
            unit_cnt_q   <= '0;
            units_left_q <= 6'd0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            drink_q      <= drink_d;
            size_q       <= size_d;
            pump_q       <= pump_d;
            done_q       <= done_d;
            step_q       <= step_d;
            unit_cnt_q   <= unit_cnt_d;
            units_left_q <= units_left_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    always_comb begin
        state = state_q;
        drink = drink_q;
        size  = size_q;
        pump  = pump_q;
        done  = done_q;
    end

endmodule

// File: tb/tb_pour_sequencer.sv
// Self-checking bench for pour_sequencer: a queue-based behavioural model checked
// every cycle, directed scenarios with literal expectations, then random buttons.
module tb_pour_sequencer;

    localparam int UNIT = 4;
    localparam int DONE = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_ok = 1'b0;
    logic       btn_back = 1'b0;
    logic [1:0] state;
    logic [2:0] drink;
    logic [3:0] size;
    logic [3:0] pump;
    logic       done;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    // Recipes as (pump index, parts) lists; zero parts ends a recipe.
    int recipe_pump  [7][4] = '{'{0,1,0,0}, '{0,2,0,0}, '{1,0,0,0}, '{2,3,0,0},
                                '{0,1,2,0}, '{3,0,0,0}, '{1,2,3,0}};
    int recipe_parts [7][4] = '{'{2,1,0,0}, '{1,2,0,0}, '{3,0,0,0}, '{1,1,0,0},
                                '{1,1,1,0}, '{2,1,0,0}, '{1,1,1,1}};

    int         m_state, m_drink, m_size, m_done, m_done_left;
    logic [3:0] m_pump;
    logic [3:0] pour_q [$];

    pour_sequencer #(.UNIT_CYCLES(UNIT), .DONE_CYCLES(DONE)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_next (btn_next),
        .btn_ok   (btn_ok),
        .btn_back (btn_back),
        .state    (state),
        .drink    (drink),
        .size     (size),
        .pump     (pump),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one button pattern for exactly one sampling edge.
    task automatic applyStimulus(input logic nxt, input logic ok, input logic back);
        btn_next = nxt;
        btn_ok   = ok;
        btn_back = back;
        @(posedge clk);
        #1;
        btn_next = 1'b0;
        btn_ok   = 1'b0;
        btn_back = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic measureRun(input logic [3:0] value, output int n);
        n = 0;
        while (pump == value && n < 400) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitState(input logic [1:0] target, input int budget);
        int n;
        n = 0;
        while (state != target && n < budget) begin
            n++;
            @(posedge clk);
            #1;
        end
        checkOutput("wait_state", 32'(state), 32'(target));
    endtask

    // Behavioural model: a pour is expanded into a queue of per-cycle pump values.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_drink = 0; m_size = 1; m_pump = 4'b0000;
            m_done = 0; m_done_left = 0;
            pour_q.delete();
        end else begin
            case (m_state)
                0: begin
                    if (btn_back) begin
                    end else if (btn_ok) m_state = 1;
                    else if (btn_next) m_drink = (m_drink + 1) % 7;
                end
                1: begin
                    if (btn_back) m_state = 0;
                    else if (btn_ok) begin
                        pour_q.delete();
                        for (int s = 0; s < 4; s++) begin
                            if (recipe_parts[m_drink][s] == 0) break;
                            repeat (recipe_parts[m_drink][s] * m_size * UNIT)
                                pour_q.push_back(4'b0001 << recipe_pump[m_drink][s]);
                        end
                        m_pump  = pour_q.pop_front();
                        m_state = 2;
                    end else if (btn_next) m_size = (m_size % 9) + 1;
                end
                2: begin
                    if (btn_back) begin
                        pour_q.delete();
                        m_pump = 4'b0000; m_state = 0;
                    end else if (pour_q.size() > 0) begin
                        m_pump = pour_q.pop_front();
                    end else begin
                        m_pump = 4'b0000; m_state = 3; m_done = 1; m_done_left = DONE;
                    end
                end
                default: begin
                    m_done_left--;
                    if (m_done_left == 0) begin
                        m_state = 0; m_done = 0; m_size = 1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en && !rst) begin
            checkOutput("model_state", 32'(state), 32'(m_state));
            checkOutput("model_drink", 32'(drink), 32'(m_drink));
            checkOutput("model_size",  32'(size),  32'(m_size));
            checkOutput("model_pump",  32'(pump),  32'(m_pump));
            checkOutput("model_done",  32'(done),  32'(m_done));
            checkOutput("pump_onehot", 32'($countones(pump) <= 1), 32'd1);
            checkOutput("pump_outside_start", 32'(state != 2'b10 && pump != 4'b0000), 32'd0);
        end
    end

    initial begin
        int n;
        int exp_drink [8] = '{1, 2, 3, 4, 5, 6, 0, 1};
        int exp_size  [9] = '{2, 3, 4, 5, 6, 7, 8, 9, 1};
        logic [3:0] exp_pumps [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        idleCycles(3);
        rst = 1'b0;
        check_en = 1'b1;
        idleCycles(2);
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_drink", 32'(drink), 32'd0);
        checkOutput("reset_size",  32'(size),  32'd1);
        checkOutput("reset_pump",  32'(pump),  32'd0);
        checkOutput("reset_done",  32'(done),  32'd0);

        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("order_back_ignored", 32'(state), 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("drink_wrap", 32'(drink), 32'(exp_drink[i]));
        end

        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("to_customize", 32'(state), 32'd1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("size_wrap", 32'(size), 32'(exp_size[i]));
        end

        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("back_beats_ok_state", 32'(state), 32'd0);
        checkOutput("back_beats_ok_pump",  32'(pump),  32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("ok_beats_next_state", 32'(state), 32'd1);
        checkOutput("ok_beats_next_drink", 32'(drink), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);

        // drink0 at size 2: 16 cycles of P0 then 8 of P1, then DONE.
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("d0_start_state", 32'(state), 32'd2);
        measureRun(4'b0001, n);
        checkOutput("d0_p0_cycles", 32'(n), 32'd16);
        measureRun(4'b0010, n);
        checkOutput("d0_p1_cycles", 32'(n), 32'd8);
        checkOutput("d0_done_state", 32'(state), 32'd3);
        n = 0;
        while (done && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        checkOutput("d0_done_cycles", 32'(n), 32'(DONE));
        checkOutput("d0_after_state", 32'(state), 32'd0);
        checkOutput("d0_after_size",  32'(size),  32'd1);
        checkOutput("d0_after_drink", 32'(drink), 32'd0);

        // drink2 at size 1, aborted during the fifth pour cycle.
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idleCycles(4);
        checkOutput("d2_pumping", 32'(pump), 32'b0010);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_state", 32'(state), 32'd0);
        checkOutput("abort_pump",  32'(pump),  32'd0);
        checkOutput("abort_drink", 32'(drink), 32'd2);
        checkOutput("abort_size",  32'(size),  32'd1);

        // drink6 at size 9: four back-to-back 36-cycle steps.
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int s = 0; s < 4; s++) begin
            measureRun(exp_pumps[s], n);
            checkOutput("d6_step_cycles", 32'(n), 32'(9 * UNIT));
        end
        checkOutput("d6_done_state", 32'(state), 32'd3);
        waitState(2'b00, 3 * DONE);

        // Asynchronous reset in the middle of a pour.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idleCycles(2);
        checkOutput("pre_reset_pump", 32'(pump), 32'b0010);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_pump",  32'(pump),  32'd0);
        checkOutput("async_reset_state", 32'(state), 32'd0);
        idleCycles(2);
        rst = 1'b0;
        idleCycles(1);

        for (int c = 0; c < 4000; c++) begin
            btn_next = ($urandom_range(0, 99) < 15);
            btn_ok   = ($urandom_range(0, 99) < 8);
            btn_back = ($urandom_range(0, 99) < 3);
            @(posedge clk);
            #1;
        end
        btn_next = 1'b0;
        btn_ok   = 1'b0;
        btn_back = 1'b0;
        idleCycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
